uart_tx: RTL and testbench

- 8-bit UART transmitter; the transmit-side partner to the team's UART receiver.
- Serialises one byte per frame onto `uart_txd`: 1 start bit, 8 data bits, optional parity bit, 1 stop bit, line idles high.
- Byte accepted from fabric logic through a valid/ready handshake; drives the board TX pin at 115200 baud from the 50 MHz clock.

---
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 / 8P1 UART transmitter with valid/ready byte intake.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      MSB_FIRST < 0 || MSB_FIRST > 1 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          txd_n;
  logic          bit_end;
  logic          done;
  logic          data_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      uart_txd <= txd_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    done     = 1'b0;
    txd_n    = 1'b1;
    data_bit = 1'b1;
    bit_end  = (cnt == LAST);

    if (state != IDLE)
      cnt_n = bit_end ? '0 : cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n = START;
          sh_n    = tx_data;
          cnt_n   = '0;
        end
      end
      START: begin
        if (bit_end)
          state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd7)
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end)
          state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is decided for the state being entered, so it lands in a flop.
    data_bit = (MSB_FIRST != 0) ? sh_n[~idx_n] : sh_n[idx_n];
    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = data_bit;
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_n = (^sh_n) ^ (PARITY_ODD != 0);
`endif
      default: txd_n = 1'b1;
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign tx_done  = done;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a per-cycle frame model.
// Two DUTs share stimulus: one MSB-first, one LSB-first.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd_m, rdy_m, done_m;
  logic       txd_l, rdy_l, done_l;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [1:0] qm[$];
  logic [1:0] ql[$];
  logic [2:0] em, el;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_m), .tx_done(done_m), .uart_txd(txd_m)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(0), .PARITY_ODD(PODD)) dut_lsb (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_l), .tx_done(done_l), .uart_txd(txd_l)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame as a sequence of line levels, first bit at the MSB.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d,
                                                input bit msb);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7-i] = msb ? d[7-i] : d[i];
`ifdef UART_TX_PARITY_EN
    return {1'b0, o, (^d) ^ (PODD != 0), 1'b1};
`else
    return {1'b0, o, 1'b1};
`endif
  endfunction

  function automatic void push_frame(input logic [7:0] d);
    logic [NB-1:0] fm, fl;
    fm = frame_bits(d, 1'b1);
    fl = frame_bits(d, 1'b0);
    for (int b = NB - 1; b >= 0; b--)
      for (int c = 0; c < CPB; c++) begin
        qm.push_back({fm[b], (b == 0 && c == CPB - 1)});
        ql.push_back({fl[b], (b == 0 && c == CPB - 1)});
      end
  endfunction

  // Model: queue front is the current cycle's expected {txd, done}.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      automatic bit acc = tx_valid && (qm.size() == 0);
      if (qm.size() != 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_frame(tx_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      em = (qm.size() != 0) ? {qm[0][1], 1'b0, qm[0][0]} : 3'b110;
      el = (ql.size() != 0) ? {ql[0][1], 1'b0, ql[0][0]} : 3'b110;
      check("cycle_msb", {txd_m, rdy_m, done_m}, em);
      check("cycle_lsb", {txd_l, rdy_l, done_l}, el);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!rdy_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", rdy_m, 1);
  endtask

  task automatic wait_accept(output int at);
    int n = 0;
    logic r = 1'b0;
    while (n < 200) begin
      r = rdy_m;
      @(negedge clk);
      n++;
      if (r) break;
    end
    check("accept_timeout", r, 1);
    at = cyc;
  endtask

  // Starts at a negedge with the DUT idle; samples mid-bit levels.
  task automatic send_cap(input logic [7:0] d, output logic [10:0] mf,
                          output logic [10:0] lf, output int done_at,
                          output logic rdy_after);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    mf = '0;
    lf = '0;
    done_at = -1;
    for (int k = 1; k <= FRAME; k++) begin
      if (k > 1) @(negedge clk);
      if ((k - 1) % CPB == CPB / 2) begin
        mf = {mf[9:0], txd_m};
        lf = {lf[9:0], txd_l};
      end
      if (done_m && done_at < 0) done_at = k;
    end
    @(negedge clk);
    rdy_after = rdy_m;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [10:0] mf, lf;
    int done_at, a1, a2, n;
    logic ra;

    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_txd", txd_m, 1);
      check("rst_ready", rdy_m, 1);
      check("rst_done", done_m, 0);
    end
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (!txd_m) n++;
    end
    check("idle_no_activity", n, 0);

    send_cap(8'hA5, mf, lf, done_at, ra);
`ifdef UART_TX_PARITY_EN
    check("a5_msb", mf, 11'b01010010101);
    check("a5_lsb", lf, 11'b01010010101);
`else
    check("a5_msb", mf, 11'b0101001011);
    check("a5_lsb", lf, 11'b0101001011);
`endif
    check("a5_done_cycle", done_at, FRAME);
    check("a5_ready_after", ra, 1);

    wait_idle();
    send_cap(8'h01, mf, lf, done_at, ra);
`ifdef UART_TX_PARITY_EN
    check("x01_msb", mf, 11'b00000000111);
    check("x01_lsb", lf, 11'b01000000011);
`else
    check("x01_msb", mf, 11'b0000000011);
    check("x01_lsb", lf, 11'b0100000001);
`endif

    wait_idle();
    fork
      send_cap(8'h00, mf, lf, done_at, ra);
      begin
        repeat (15) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
`ifdef UART_TX_PARITY_EN
    check("busy_frame", mf, 11'b00000000001);
`else
    check("busy_frame", mf, 11'b0000000001);
`endif
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (!txd_m) n++;
    end
    check("busy_no_second", n, 0);

    wait_idle();
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    wait_accept(a1);
    tx_data  = 8'hC3;
    wait_accept(a2);
    tx_valid = 1'b0;
    check("b2b_spacing", a2 - a1, FRAME + 1);

    wait_idle();
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_txd", txd_m, 1);
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_m || done_l) n++;
    end
    check("midrst_no_done", n, 0);

`ifdef UART_TX_PARITY_EN
    wait_idle();
    send_cap(8'h07, mf, lf, done_at, ra);
    check("par_x07", mf[1], 1);
    wait_idle();
    send_cap(8'h03, mf, lf, done_at, ra);
    check("par_x03", mf[1], 0);
`endif

    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      wait_accept(a1);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
